// File: rtl/stream_packet_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_packet_arbiter_if                                                 |
// | N-source packet streams in, one arbitrated stream out, plus status.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface stream_packet_arbiter_if #(
  parameter int T_DATA_WIDTH = 32,
  parameter int N_SOURCES    = 3,
  parameter int T_SEL_WIDTH  = $clog2(N_SOURCES)
);
  logic [N_SOURCES-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [N_SOURCES-1:0]                   s_last_i;
  logic [N_SOURCES-1:0]                   s_valid_i;
  logic [N_SOURCES-1:0]                   s_ready_o;
  logic [T_DATA_WIDTH-1:0]                m_data_o;
  logic                                   m_last_o;
  logic                                   m_valid_o;
  logic                                   m_ready_i;
  logic [T_SEL_WIDTH-1:0]                 grant_o;
  logic                                   busy_o;
  logic                                   err_o;

  // Arbiter side.
  modport master (
    input  s_data_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o, grant_o, busy_o, err_o
  );

  // Environment side: sources plus the downstream upsizer.
  modport slave (
    output s_data_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o, grant_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/stream_packet_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_packet_arbiter                                                    |
// | Round-robin, packet-atomic arbiter feeding one upsizer input port.       |
// | Optional stall watchdog: define STREAM_ARB_WATCHDOG_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stream_packet_arbiter #(
  parameter int T_DATA_WIDTH = 32,
  parameter int N_SOURCES    = 3,
  parameter int T_SEL_WIDTH  = $clog2(N_SOURCES),
  parameter int WDOG_CYCLES  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  stream_packet_arbiter_if.master bus
);

  if (N_SOURCES < 2 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("stream_packet_arbiter: N_SOURCES must be >= 2 and WDOG_CYCLES >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [T_SEL_WIDTH-1:0] c_RR_INIT = T_SEL_WIDTH'(N_SOURCES - 1);

  state_t                  r_state;
  logic [T_SEL_WIDTH-1:0]  r_grant;
  logic [T_SEL_WIDTH-1:0]  r_rr_ptr;
  logic                    r_busy;

  logic [T_SEL_WIDTH-1:0]  w_winner;
  logic [T_SEL_WIDTH-1:0]  w_cand;
  logic                    w_any;
  logic                    w_locked;
  logic                    w_own_valid;
  logic                    w_own_last;
  logic [T_DATA_WIDTH-1:0] w_own_data;
  logic                    w_forced;
  logic                    w_xfer;
  logic                    w_done;

  // Scan from farthest to nearest so the candidate right after rr_ptr wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_cand   = '0;
    for (int k = N_SOURCES; k >= 1; k--) begin
      w_cand = T_SEL_WIDTH'((int'(r_rr_ptr) + k) % N_SOURCES);
      if (bus.s_valid_i[w_cand]) begin
        w_winner = w_cand;
        w_any    = 1'b1;
      end
    end
  end

  assign w_locked    = (r_state == ST_LOCKED);
  assign w_own_valid = bus.s_valid_i[r_grant];
  assign w_own_last  = bus.s_last_i[r_grant];
  assign w_own_data  = bus.s_data_i[r_grant];
  assign w_xfer      = w_locked && w_own_valid && bus.m_ready_i && !w_forced;
  assign w_done      = (w_xfer && w_own_last) || (w_forced && bus.m_ready_i);

`ifdef STREAM_ARB_WATCHDOG_EN
  localparam int                  c_WDOG_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(WDOG_CYCLES);

  logic [c_WDOG_W-1:0] r_wdog_cnt;
  logic                r_err;

  assign w_forced = w_locked && (r_wdog_cnt == c_WDOG_MAX);

  // Held at zero outside LOCKED, so every new ownership starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_forced && bus.m_ready_i;
      if (!w_locked || w_xfer) begin
        r_wdog_cnt <= '0;
      end else if (!w_own_valid && !w_forced) begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
    end
  end

  assign bus.err_o = r_err;
`else
  assign w_forced  = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= c_RR_INIT;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_state <= ST_LOCKED;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_done) begin
            r_rr_ptr <= r_grant;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency forwarding path from the owner to the upsizer.
  always_comb begin
    bus.m_data_o  = '0;
    bus.m_last_o  = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.s_ready_o = '0;
    if (w_forced) begin
      bus.m_valid_o = 1'b1;
      bus.m_last_o  = 1'b1;
    end else if (w_locked) begin
      bus.m_data_o           = w_own_data;
      bus.m_last_o           = w_own_last;
      bus.m_valid_o          = w_own_valid;
      bus.s_ready_o[r_grant] = bus.m_ready_i;
    end
  end

  assign bus.grant_o = r_grant;
  assign bus.busy_o  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stream_packet_arbiter                                                 |
// | Queue-driven sources, expected-beat scoreboard and directed scenarios.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stream_packet_arbiter;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int WD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_packet_arbiter_if #(.T_DATA_WIDTH(DW), .N_SOURCES(NS), .T_SEL_WIDTH(SW)) bus ();

  stream_packet_arbiter #(
    .T_DATA_WIDTH(DW), .N_SOURCES(NS), .T_SEL_WIDTH(SW), .WDOG_CYCLES(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int err_cnt     = 0;
  bit wd_phase    = 1'b0;

  // Source entry: {bubble, last, data}; expected entry: {grant, last, data}.
  logic [DW+1:0]  src_q [NS][$];
  logic [SW+DW:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int s, input logic [DW-1:0] data, input logic last);
    src_q[s].push_back({1'b0, last, data});
    exp_q.push_back({SW'(s), last, data});
  endtask

  task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) push_beat(s, DW'(base + DW'(i)), (i == n - 1));
  endtask

  task automatic push_bubbles(input int s, input int n);
    for (int i = 0; i < n; i++) src_q[s].push_back({1'b1, 1'b0, {DW{1'b0}}});
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < max) begin
      tick();
      n++;
    end
    check(name, {32'(exp_q.size()), bus.busy_o}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_state",
          {bus.grant_o, bus.busy_o, bus.err_o, bus.m_valid_o, bus.m_last_o, bus.s_ready_o, bus.m_data_o},
          64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Source driver: a beat leaves its queue once it was seen accepted; bubbles last one cycle.
  initial begin : drv
    logic [NS-1:0] fire;
    logic [NS-1:0] bubble_shown;
    bus.s_valid_i = '0;
    bus.s_last_i  = '0;
    bus.s_data_i  = '0;
    fire          = '0;
    bubble_shown  = '0;
    forever begin
      @(negedge clk);
      fire = bus.s_valid_i & bus.s_ready_o;
      @(posedge clk);
      #2;
      for (int s = 0; s < NS; s++) begin
        if ((fire[s] || bubble_shown[s]) && src_q[s].size() > 0) void'(src_q[s].pop_front());
        bubble_shown[s]  = 1'b0;
        bus.s_valid_i[s] = 1'b0;
        bus.s_last_i[s]  = 1'b0;
        bus.s_data_i[s]  = '0;
        if (src_q[s].size() > 0) begin
          if (src_q[s][0][DW+1]) begin
            bubble_shown[s] = 1'b1;
          end else begin
            bus.s_valid_i[s] = 1'b1;
            bus.s_last_i[s]  = src_q[s][0][DW];
            bus.s_data_i[s]  = src_q[s][0][DW-1:0];
          end
        end
      end
    end
  end

  // Monitor: per-cycle output invariants plus scoreboard pop on every accepted beat.
  initial begin : mon
    logic [SW+DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.err_o) err_cnt++;
      if (!wd_phase) begin
        if (bus.busy_o)
          check("locked_mux", {bus.s_ready_o, bus.m_valid_o},
                {(bus.m_ready_i ? (NS'(1) << bus.grant_o) : NS'(0)), bus.s_valid_i[bus.grant_o]});
        else
          check("idle_outputs", {bus.m_valid_o, bus.m_last_o, bus.s_ready_o, bus.m_data_o}, 64'd0);
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got grant=%0d last=%0b data=0x%0h, expected none",
                   bus.grant_o, bus.m_last_o, bus.m_data_o);
        end else begin
          e = exp_q.pop_front();
          check("beat", {bus.grant_o, bus.m_last_o, bus.m_data_o}, e);
        end
      end
    end
  end

  initial begin : timeout
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : main
    bus.m_ready_i = 1'b0;
    #1;
    do_reset();

    // Single source 1, three beats, free-flowing sink.
    bus.m_ready_i = 1'b1;
    push_pkt(1, 3, 32'hA0);
    #2;
    check("t1_not_yet_granted", bus.busy_o, 1'b0);
    tick();
    check("t1_grant", {bus.busy_o, bus.grant_o}, {1'b1, 2'd1});
    tick();
    tick();
    check("t1_busy_on_last", bus.busy_o, 1'b1);
    tick();
    check("t1_busy_fall", bus.busy_o, 1'b0);
    wait_drain("t1_drain", 20);

    // Round robin with all sources requesting: 3-cycle period, 1 idle between packets.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) push_pkt(s, 2, DW'(32'h100 * (s + 1) + 32'h10 * r));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t2_grant", {bus.busy_o, bus.grant_o}, {1'b1, SW'(k % NS)});
      tick();
      tick();
      check("t2_gap", bus.busy_o, 1'b0);
    end
    wait_drain("t2_drain", 20);

    // Backpressure mid-packet on source 0.
    push_pkt(0, 4, 32'h300);
    tick();
    check("t3_grant", {bus.busy_o, bus.grant_o}, {1'b1, 2'd0});
    tick();
    tick();
    bus.m_ready_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t3_hold", {bus.m_valid_o, bus.s_ready_o, bus.grant_o, bus.m_data_o},
            {1'b1, 3'b000, 2'd0, 32'h302});
    end
    @(posedge clk);
    #1;
    bus.m_ready_i = 1'b1;
    wait_drain("t3_drain", 20);

    // Owner 1 stalls 5 cycles while source 2 waits.
    push_beat(1, 32'h400, 1'b0);
    push_bubbles(1, 5);
    push_beat(1, 32'h401, 1'b0);
    push_beat(1, 32'h402, 1'b1);
    push_pkt(2, 2, 32'h410);
    tick();
    check("t4_grant", {bus.busy_o, bus.grant_o}, {1'b1, 2'd1});
    tick();
    #2;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall", {bus.busy_o, bus.grant_o, bus.s_ready_o[2], bus.m_valid_o},
            {1'b1, 2'd1, 1'b0, 1'b0});
    end
    wait_drain("t4_drain", 30);

    // Reset on beat 2 of 4 from source 2.
    push_pkt(2, 4, 32'h500);
    tick();
    check("t5_grant", {bus.busy_o, bus.grant_o}, {1'b1, 2'd2});
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_reset_async", {bus.m_valid_o, bus.busy_o, bus.s_ready_o, bus.grant_o}, 64'd0);
    check("t5_abandoned", 32'(exp_q.size()), 64'd3);
    src_q[2].delete();
    exp_q.delete();
    push_pkt(0, 2, 32'h600);
    push_pkt(1, 1, 32'h700);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_first_after_reset", {bus.busy_o, bus.grant_o}, {1'b1, 2'd0});
    wait_drain("t5_drain", 20);

`ifdef STREAM_ARB_WATCHDOG_EN
    // Owner 2 goes silent after one beat; the watchdog closes its packet.
    wd_phase = 1'b1;
    push_beat(2, 32'h800, 1'b0);
    exp_q.push_back({2'd2, 1'b1, 32'h0});
    push_pkt(0, 1, 32'h900);
    wait_drain("t6_drain", 60);
    check("t6_err_pulses", 32'(err_cnt), 64'd1);
    wd_phase = 1'b0;
`else
    check("no_wdog_err", 32'(err_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
